// File: rtl/gen_multi_pkg.sv
// Shared constants, mode encoding and sine-table generator for the multi-channel
// test-signal generator.
package gen_multi_pkg;

    localparam logic [2:0] GEN_PINC = 3'd0;
    localparam logic [2:0] GEN_ATTN = 3'd1;
    localparam logic [2:0] GEN_STEP = 3'd2;
    localparam logic [2:0] GEN_END  = 3'd3;
    localparam logic [2:0] GEN_MODE = 3'd4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TONE  = 2'd1,
        MODE_SWEEP = 2'd2,
        MODE_NOISE = 2'd3
    } mode_e;

    // x^17 + x^14 + 1, expressed as bit indices of the shift register
    localparam int LFSR_W      = 17;
    localparam int LFSR_TAP_HI = 16;
    localparam int LFSR_TAP_LO = 13;

    localparam int FULL_SCALE = 131071;
    localparam int ATTN_W     = 17;
    localparam int RAW_W      = 18;

    // Quarter-wave entry sampled half an index off zero so mirroring is exact
    function automatic logic [16:0] sin_entry(input int idx, input int lut_aw);
        real ang;
        real val;
        ang = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / real'(4 << lut_aw);
        val = real'(FULL_SCALE) * $sin(ang);
        return 17'($rtoi(val + 0.5));
    endfunction

endpackage

// File: rtl/gen_multi_if.sv
// Configuration write port and output sample bus of the test-signal generator.
interface gen_multi_if #(
    parameter int NCH   = 2,
    parameter int OUT_W = 18
);
    // wide enough to address one past the last channel
    localparam int CH_W = $clog2(NCH + 1);

    logic                    cfg_wr;
    logic [CH_W-1:0]         cfg_ch;
    logic [2:0]              cfg_addr;
    logic [31:0]             cfg_data;
    logic                    phase_zero;
    logic signed [OUT_W-1:0] gen_data;
    logic                    gen_valid;

    modport master (
        output cfg_wr, cfg_ch, cfg_addr, cfg_data, phase_zero,
        input  gen_data, gen_valid
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_addr, cfg_data, phase_zero,
        output gen_data, gen_valid
    );
endinterface

// File: rtl/gen_sin_lut.sv
// Quarter-wave sine ROM with registered output; quadrant mirror and sign are
// folded into the read so the output is a full signed sine sample.
module gen_sin_lut
    import gen_multi_pkg::*;
#(
    parameter int LUT_AW = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LUT_AW+1:0]       phase,
    output logic signed [RAW_W-1:0] sine
);
    localparam int DEPTH = 1 << LUT_AW;

    logic [16:0]       rom [DEPTH];
    logic [LUT_AW-1:0] addr;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [16:0] ENTRY = sin_entry(gi, LUT_AW);
        assign rom[gi] = ENTRY;
    end

    // quadrants 1 and 3 walk the table backwards, 2 and 3 are negated
    assign addr = phase[LUT_AW] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sine <= '0;
        end else if (phase[LUT_AW+1]) begin
            sine <= -$signed({1'b0, rom[addr]});
        end else begin
            sine <= $signed({1'b0, rom[addr]});
        end
    end
endmodule

// File: rtl/gen_multi.sv
// Multi-channel tone / chirp / noise generator: per-channel accumulator and
// attenuator, five-stage pipeline, saturating channel sum.
module gen_multi
    import gen_multi_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 18,
    parameter int LUT_AW  = 10
) (
    input  logic       adc_clk,
    input  logic       rst_n,
    gen_multi_if.slave bus
);
    localparam int CH_W   = $clog2(NCH + 1);
    localparam int PROD_W = RAW_W + ATTN_W + 1;
    localparam int SW     = (OUT_W > RAW_W ? OUT_W : RAW_W) + 2 + $clog2(NCH);
    localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(1 << (ATTN_W - 1));
    localparam logic signed [SW-1:0]     SAT_HI   = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0]     SAT_LO   = SW'(-(1 << (OUT_W - 1)));

    logic                    pz_reg;
    logic [4:0]              valid_reg;
    logic signed [OUT_W-1:0] gen_data_reg;
    logic signed [SW-1:0]    term [NCH];
    logic signed [SW-1:0]    sum;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [PHASE_W-1:0]      pinc_reg, step_reg, end_reg, inc_reg, acc_reg, inc_step;
        logic [ATTN_W-1:0]       attn_reg, attn_s0_reg, attn_s1_reg;
        mode_e                   mode_reg, src_s0_reg, src_s1_reg;
        logic [LFSR_W-1:0]       lfsr_reg;
        logic signed [RAW_W-1:0] noise_s1_reg, sine_s1, raw_s1, scaled_s3_reg;
        logic signed [PROD_W-1:0] prod_s2_reg;
        logic                    wr, wr_pinc, enter_sweep;

        assign wr          = bus.cfg_wr && (bus.cfg_ch == CH_W'(gi));
        assign wr_pinc     = wr && (bus.cfg_addr == GEN_PINC);
        assign enter_sweep = wr && (bus.cfg_addr == GEN_MODE) &&
                             (bus.cfg_data[1:0] == MODE_SWEEP) && (mode_reg != MODE_SWEEP);
        assign inc_step    = inc_reg + step_reg;

        always_ff @(posedge adc_clk or negedge rst_n) begin
            if (!rst_n) begin
                pinc_reg <= '0;
                attn_reg <= '0;
                step_reg <= '0;
                end_reg  <= '0;
                mode_reg <= MODE_OFF;
            end else if (wr) begin
                case (bus.cfg_addr)
                    GEN_PINC: pinc_reg <= PHASE_W'(bus.cfg_data);
                    GEN_ATTN: attn_reg <= bus.cfg_data[ATTN_W-1:0];
                    GEN_STEP: step_reg <= PHASE_W'(bus.cfg_data);
                    GEN_END:  end_reg  <= PHASE_W'(bus.cfg_data);
                    GEN_MODE: mode_reg <= mode_e'(bus.cfg_data[1:0]);
                    default:  ;
                endcase
            end
        end

        // a fresh PINC write always wins over restore and sweep wrap
        always_ff @(posedge adc_clk or negedge rst_n) begin
            if (!rst_n) begin
                inc_reg <= '0;
            end else if (wr_pinc) begin
                inc_reg <= PHASE_W'(bus.cfg_data);
            end else if (pz_reg || enter_sweep) begin
                inc_reg <= pinc_reg;
            end else if (mode_reg == MODE_SWEEP) begin
                inc_reg <= (inc_step > end_reg) ? pinc_reg : inc_step;
            end
        end

        // S0: accumulator / LFSR, with the mode and gain that produced them
        always_ff @(posedge adc_clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg     <= '0;
                lfsr_reg    <= LFSR_W'(gi + 1);
                src_s0_reg  <= MODE_OFF;
                attn_s0_reg <= '0;
            end else begin
                src_s0_reg  <= mode_reg;
                attn_s0_reg <= attn_reg;
                if (mode_reg == MODE_NOISE) begin
                    lfsr_reg <= {lfsr_reg[LFSR_W-2:0], lfsr_reg[LFSR_TAP_HI] ^ lfsr_reg[LFSR_TAP_LO]};
                end
                if (pz_reg || mode_reg == MODE_OFF) begin
                    acc_reg <= '0;
                end else if (mode_reg == MODE_TONE) begin
                    acc_reg <= acc_reg + pinc_reg;
                end else if (mode_reg == MODE_SWEEP) begin
                    acc_reg <= acc_reg + inc_reg;
                end
            end
        end

        gen_sin_lut #(.LUT_AW(LUT_AW)) u_lut (
            .clk   (adc_clk),
            .rst_n (rst_n),
            .phase (acc_reg[PHASE_W-1 -: LUT_AW+2]),
            .sine  (sine_s1)
        );

        assign raw_s1 = (src_s1_reg == MODE_NOISE) ? noise_s1_reg :
                        (src_s1_reg == MODE_OFF)   ? '0 : sine_s1;

        // S1 side-band, S2 multiply, S3 round
        always_ff @(posedge adc_clk or negedge rst_n) begin
            if (!rst_n) begin
                src_s1_reg    <= MODE_OFF;
                attn_s1_reg   <= '0;
                noise_s1_reg  <= '0;
                prod_s2_reg   <= '0;
                scaled_s3_reg <= '0;
            end else begin
                src_s1_reg    <= src_s0_reg;
                attn_s1_reg   <= attn_s0_reg;
                noise_s1_reg  <= $signed({~lfsr_reg[LFSR_W-1], ~lfsr_reg[LFSR_W-1], lfsr_reg[LFSR_W-2:0]});
                prod_s2_reg   <= raw_s1 * $signed({1'b0, attn_s1_reg});
                scaled_s3_reg <= RAW_W'((prod_s2_reg + HALF_LSB) >>> ATTN_W);
            end
        end

        if (OUT_W < RAW_W) begin : g_round
            localparam int SH = RAW_W - OUT_W;
            logic signed [RAW_W:0] biased;
            assign biased   = (RAW_W + 1)'(scaled_s3_reg) + (RAW_W + 1)'(1 << (SH - 1));
            assign term[gi] = SW'(biased >>> SH);
        end else begin : g_wide
            assign term[gi] = SW'(scaled_s3_reg);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + term[i];
        end
    end

    // S4: saturate; phase_zero is registered once so every channel clears together
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pz_reg       <= 1'b0;
            valid_reg    <= '0;
            gen_data_reg <= '0;
        end else begin
            pz_reg    <= bus.phase_zero;
            valid_reg <= {valid_reg[3:0], 1'b1};
            if (sum > SAT_HI) begin
                gen_data_reg <= OUT_W'(SAT_HI);
            end else if (sum < SAT_LO) begin
                gen_data_reg <= OUT_W'(SAT_LO);
            end else begin
                gen_data_reg <= OUT_W'(sum);
            end
        end
    end

    assign bus.gen_data  = gen_data_reg;
    assign bus.gen_valid = valid_reg[4];
endmodule

// File: tb/tb_gen_multi.sv
// Randomised scoreboard bench for gen_multi: a behavioural model predicts every
// output sample, a monitor compares whenever gen_valid is high.
module tb_gen_multi;
    import gen_multi_pkg::*;

    localparam int NCH = 2, PHASE_W = 32, OUT_W = 18, LUT_AW = 10;
    localparam int CH_W = $clog2(NCH + 1);
    localparam real PI = 3.14159265358979323846;

    logic adc_clk = 1'b0;
    logic rst_n   = 1'b0;

    gen_multi_if #(.NCH(NCH), .OUT_W(OUT_W)) bus ();

    gen_multi #(.NCH(NCH), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
        .adc_clk (adc_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 adc_clk = ~adc_clk;

    // reference model state
    logic [31:0] m_pinc [NCH];
    logic [31:0] m_step [NCH];
    logic [31:0] m_end  [NCH];
    logic [31:0] m_inc  [NCH];
    logic [31:0] m_acc  [NCH];
    logic [16:0] m_lfsr [NCH];
    int          m_attn [NCH];
    int          m_mode [NCH];
    bit          m_pz;
    int          cyc;
    int          exp_q [$];
    int          checks = 0;
    int          errors = 0;

    function automatic int sine_of(input logic [31:0] acc);
        int  k;
        real v;
        k = int'(acc >> (32 - (LUT_AW + 2)));
        v = 131071.0 * $sin(2.0 * PI * (real'(k) + 0.5) / real'(4 << LUT_AW));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int noise_of(input logic [16:0] l);
        return int'(l[15:0]) - (l[16] ? 0 : 65536);
    endfunction

    function automatic int scale(input int raw, input int attn);
        longint p;
        p = longint'(raw) * longint'(attn);
        return int'((p + 65536) >>> 17);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pinc[c] = '0; m_step[c] = '0; m_end[c] = '0; m_inc[c] = '0; m_acc[c] = '0;
            m_attn[c] = 0;  m_mode[c] = 0;  m_lfsr[c] = 17'(c + 1);
        end
        m_pz = 1'b0;
        cyc  = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit          w;
        int          ch, addr, total;
        logic [31:0] d;
        w = bus.cfg_wr; ch = int'(bus.cfg_ch); addr = int'(bus.cfg_addr); d = bus.cfg_data;
        total = 0;
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] t, new_inc;
            int raw;
            if (m_mode[c] == 3) m_lfsr[c] = {m_lfsr[c][15:0], m_lfsr[c][16] ^ m_lfsr[c][13]};
            new_inc = m_inc[c];
            if (w && ch == c && addr == 0) new_inc = d;
            else if (m_pz || (w && ch == c && addr == 4 && d[1:0] == 2'd2 && m_mode[c] != 2))
                new_inc = m_pinc[c];
            else if (m_mode[c] == 2) begin
                t = m_inc[c] + m_step[c];
                new_inc = (t > m_end[c]) ? m_pinc[c] : t;
            end
            if (m_pz || m_mode[c] == 0) m_acc[c] = '0;
            else if (m_mode[c] == 1)    m_acc[c] = m_acc[c] + m_pinc[c];
            else if (m_mode[c] == 2)    m_acc[c] = m_acc[c] + m_inc[c];
            m_inc[c] = new_inc;
            raw = (m_mode[c] == 0) ? 0 : (m_mode[c] == 3) ? noise_of(m_lfsr[c]) : sine_of(m_acc[c]);
            total += scale(raw, m_attn[c]);
        end
        if (w && ch < NCH) begin
            case (addr)
                0: m_pinc[ch] = d;
                1: m_attn[ch] = int'(d[16:0]);
                2: m_step[ch] = d;
                3: m_end[ch]  = d;
                4: m_mode[ch] = int'(d[1:0]);
                default: ;
            endcase
        end
        m_pz = bus.phase_zero;
        if (total > 131071) total = 131071;
        if (total < -131072) total = -131072;
        exp_q.push_back(total);
        cyc++;
    endtask

    initial forever begin
        @(posedge adc_clk);
        if (rst_n) model_step();
    end

    // monitor
    initial forever begin
        @(negedge adc_clk);
        if (rst_n) begin
            checks++;
            if (bus.gen_valid !== (cyc >= 5)) begin
                errors++;
                $display("FAIL gen_valid cyc=%0d got %b want %b", cyc, bus.gen_valid, cyc >= 5);
            end
            if (bus.gen_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sample_underrun cyc=%0d got %0d want <queued>", cyc, int'(bus.gen_data));
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(bus.gen_data) !== e) begin
                        errors++;
                        $display("FAIL gen_data cyc=%0d got %0d want %0d", cyc, int'(bus.gen_data), e);
                    end
                end
            end else begin
                checks++;
                if (bus.gen_data !== '0) begin
                    errors++;
                    $display("FAIL idle_data cyc=%0d got %0d want 0", cyc, int'(bus.gen_data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog time=%0t got running want finished", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    task automatic cfg(input int ch, input int addr, input logic [31:0] d, input bit pz);
        bus.cfg_wr = 1'b1; bus.cfg_ch = CH_W'(ch); bus.cfg_addr = 3'(addr);
        bus.cfg_data = d; bus.phase_zero = pz;
        $display("cfg ch=%0d addr=%0d data=0x%08h pz=%0b", ch, addr, d, pz);
        @(negedge adc_clk);
        bus.cfg_wr = 1'b0; bus.phase_zero = 1'b0;
    endtask

    task automatic pulse_pz();
        bus.phase_zero = 1'b1;
        $display("phase_zero");
        @(negedge adc_clk);
        bus.phase_zero = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge adc_clk);
    endtask

    initial begin
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.phase_zero = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(10);

        // single tone, quarter-rate
        cfg(0, GEN_ATTN, 32'd131071, 1'b0);
        cfg(0, GEN_PINC, 32'h4000_0000, 1'b0);
        cfg(0, GEN_MODE, 32'd1, 1'b0);
        idle(16);
        cfg(0, GEN_PINC, 32'h0A00_0000, 1'b0);
        idle(12);

        // both channels in phase: saturating sum
        cfg(1, GEN_ATTN, 32'd131071, 1'b0);
        cfg(1, GEN_PINC, 32'h0A00_0000, 1'b0);
        cfg(1, GEN_MODE, 32'd1, 1'b0);
        pulse_pz();
        idle(40);

        // sweep at the listed rates, PINC write landing on the wrap edge
        cfg(1, GEN_MODE, 32'd0, 1'b0);
        cfg(0, GEN_PINC, 32'd1000, 1'b0);
        cfg(0, GEN_STEP, 32'd100, 1'b0);
        cfg(0, GEN_END, 32'd1500, 1'b0);
        cfg(0, GEN_MODE, 32'd2, 1'b0);
        idle(5);
        cfg(0, GEN_PINC, 32'd1200, 1'b0);
        idle(10);

        // visible sweep, then PINC write together with phase_zero
        cfg(0, GEN_STEP, 32'd100 << 18, 1'b0);
        cfg(0, GEN_END, 32'd1500 << 18, 1'b0);
        cfg(0, GEN_PINC, 32'd1000 << 18, 1'b0);
        idle(20);
        cfg(0, GEN_PINC, 32'd900 << 18, 1'b1);
        idle(20);

        // noise on both channels from their seeds
        cfg(0, GEN_MODE, 32'd3, 1'b0);
        cfg(1, GEN_MODE, 32'd3, 1'b0);
        idle(30);

        // writes that must be ignored
        cfg(NCH, GEN_ATTN, 32'd5, 1'b0);
        cfg(NCH + 1, GEN_MODE, 32'd0, 1'b0);
        cfg(0, 6, 32'hFFFF_FFFF, 1'b0);
        cfg(1, 7, 32'h0000_0000, 1'b0);
        idle(10);

        // random traffic
        for (int i = 0; i < 250; i++) begin
            int r, a;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            if (r < 4)       cfg($urandom_range(0, 3), a, (a == 2) ? ($urandom >> 8) : $urandom, $urandom_range(0, 7) == 0);
            else if (r == 4) pulse_pz();
            else             idle(1);
        end

        // mid-sweep asynchronous reset
        cfg(0, GEN_ATTN, 32'd131071, 1'b0);
        cfg(0, GEN_PINC, 32'd1000 << 18, 1'b0);
        cfg(0, GEN_STEP, 32'd100 << 18, 1'b0);
        cfg(0, GEN_END, 32'd1500 << 18, 1'b0);
        cfg(0, GEN_MODE, 32'd2, 1'b0);
        idle(12);
        @(posedge adc_clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.gen_data !== '0 || bus.gen_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got data=%0d valid=%b want data=0 valid=0", int'(bus.gen_data), bus.gen_valid);
        end
        @(posedge adc_clk);
        #2;
        rst_n = 1'b1;
        @(negedge adc_clk);
        idle(8);
        cfg(0, GEN_ATTN, 32'd131071, 1'b0);
        cfg(0, GEN_PINC, 32'd1000 << 18, 1'b0);
        cfg(0, GEN_STEP, 32'd100 << 18, 1'b0);
        cfg(0, GEN_END, 32'd1500 << 18, 1'b0);
        cfg(0, GEN_MODE, 32'd2, 1'b0);
        cfg(1, GEN_ATTN, 32'd70000, 1'b0);
        cfg(1, GEN_MODE, 32'd3, 1'b0);
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
